// File: rtl/rip_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues reads to a 1-cycle synchronous
// instruction memory, parks a returned word across stalls and squashes it on redirect.
module rip_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst_code,
   output logic [31:0] if_pc,
   output logic        de_ready,
   output logic [31:0] fetch_count
);

   logic [31:0] pc;
   logic        req_valid;
   logic [31:0] req_pc;
   logic        hold_valid;
   logic [31:0] hold_inst;
   logic [31:0] hold_pc;
   logic [31:0] count_q;

   logic        issue;
   logic [31:0] issue_addr;
   logic        src_valid;
   logic [31:0] src_inst;
   logic [31:0] src_pc;
   logic        capture;

   // Redirect wins over stall: the new target must be requested even while decode is frozen.
   assign issue      = rst_n & (redirect | ~stall);
   assign issue_addr = redirect ? (redirect_pc & ~32'h0000_0003) : pc;

   // A parked word is always older than anything returning from memory, so it goes first.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      src_valid = 1'b0;
      src_inst  = NOP_INST;
      src_pc    = pc;
      if (hold_valid) begin
         src_valid = 1'b1;
         src_inst  = hold_inst;
         src_pc    = hold_pc;
      end else if (req_valid) begin
         src_valid = 1'b1;
         src_inst  = imem_rdata;
         src_pc    = req_pc;
      end
   end

   assign capture = ~redirect & stall & req_valid & ~hold_valid;

   assign imem_en     = issue;
   assign imem_addr   = issue_addr;
   assign inst_code   = rst_n ? src_inst : NOP_INST;
   assign if_pc       = rst_n ? src_pc : 32'h0000_0000;
   assign de_ready    = rst_n & src_valid & ~stall & ~redirect;
   assign fetch_count = count_q;

   // Control state: synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) begin
         pc         <= RESET_PC;
         req_valid  <= 1'b0;
         hold_valid <= 1'b0;
         count_q    <= 32'h0000_0000;
      end else begin
         if (issue) begin
            req_valid <= 1'b1;
            pc        <= issue_addr + 32'd4;
         end else begin
            req_valid <= 1'b0;
         end

         if (redirect || !stall) begin
            hold_valid <= 1'b0;
         end else if (capture) begin
            hold_valid <= 1'b1;
         end

         if (de_ready) begin
            count_q <= count_q + 32'd1;
         end
      end
   end

   // NOTE: datapath registers carry no reset; their valid flags above gate every use.
   always_ff @(posedge clk) begin
      if (issue) begin
         req_pc <= issue_addr;
      end
      if (capture) begin
         hold_inst <= imem_rdata;
         hold_pc   <= req_pc;
      end
   end

endmodule
